layer_serial_feeder: RTL

Transmit-side companion to the serial `layer` datapath: it accepts a whole input vector of `SIZE` words in parallel over a valid/ready handshake and emits it one word per transfer on a serial stream.
- Framing marks the first and last word of each vector.
- The stream is in the word order the layer's serial input consumes, and matches its serial output order: element 0 first.
- A one-vector holding slot lets the next vector be queued while the current one is shifting, so frames go back-to-back with no idle cycle.
- The block sits between the host/sample source and the first layer's `x_input`.

---
 rtl/layer_serial_feeder.sv | 70 +++++++
 1 files changed

// File: rtl/layer_serial_feeder.sv
// layer_serial_feeder: parallel vector in, one word per transfer out, with a one-vector holding slot.
module layer_serial_feeder #(
  parameter int SIZE     = 3,
  parameter int BIT_SIZE = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SIZE-1:0][BIT_SIZE-1:0]     in_data,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [BIT_SIZE-1:0]               x_out,
  output logic                              x_first,
  output logic                              x_last
);
  localparam int IW = SIZE > 1 ? $clog2(SIZE) : 1;
  logic [SIZE-1:0][BIT_SIZE-1:0] act_q, act_d, pend_q, pend_d;
  logic                          act_v_q, act_v_d, pend_v_q, pend_v_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic                          accept, xfer, at_last;
  assign at_last   = idx_q == IW'(SIZE - 1);
  assign accept    = in_valid & !pend_v_q;
  assign xfer      = act_v_q & out_ready;
  assign in_ready  = !pend_v_q;
  assign out_valid = act_v_q;
  assign x_out     = act_q[0];
  assign x_first   = act_v_q & (idx_q == '0);
  assign x_last    = act_v_q & at_last;
  always_comb begin
    act_d    = act_q;
    pend_d   = pend_q;
    act_v_d  = act_v_q;
    pend_v_d = pend_v_q;
    idx_d    = idx_q;
    if (xfer && !at_last) begin
      act_d = act_q >> BIT_SIZE;
      idx_d = idx_q + IW'(1);
    end
    if (xfer && at_last) begin
      idx_d    = '0;
      pend_v_d = 1'b0;
      act_d    = pend_v_q ? pend_q : accept ? in_data : '0;
      act_v_d  = pend_v_q | accept;
    end else if (accept) begin
      if (!act_v_q) begin
        act_d   = in_data;
        act_v_d = 1'b1;
      end else begin
        pend_d   = in_data;
        pend_v_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q    <= '0;
      pend_q   <= '0;
      act_v_q  <= 1'b0;
      pend_v_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      act_q    <= act_d;
      pend_q   <= pend_d;
      act_v_q  <= act_v_d;
      pend_v_q <= pend_v_d;
      idx_q    <= idx_d;
    end
  end
endmodule
